// File: rtl/moore_seq_detector_param.sv
// Parametrised Moore serial-pattern detector.
// A PAT_W-bit history window is compared against a run-time reloadable pattern once
// enough valid bits have been seen. Overlapping or non-overlapping detection is selected
// per stream bit, and a saturating counter tallies matches.
module moore_seq_detector_param #(
   parameter int unsigned      PAT_W   = 4,
   parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1001),
   parameter int unsigned      CNT_W   = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         x,
   input  logic                         overlap,
   input  logic                         pat_load,
   input  logic [PAT_W-1:0]             pat_in,
   input  logic                         cnt_clr,
   output logic                         y,
   output logic [CNT_W-1:0]             match_count,
   output logic [$clog2(PAT_W+1)-1:0]   fill
);

   localparam int unsigned FILL_W = $clog2(PAT_W + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   // Architectural state: {r_shreg, r_fill} forms the detector state, r_fill being
   // the number of history bits that may take part in a match.
   logic [PAT_W-1:0]  r_pat,   w_pat_d;
   logic [PAT_W-1:0]  r_shreg, w_shreg_d;
   logic [FILL_W-1:0] r_fill,  w_fill_d;
   logic              r_y,     w_y_d;
   logic [CNT_W-1:0]  r_cnt,   w_cnt_d;

   // Datapath helpers for the current stream bit.
   logic [PAT_W-1:0]  w_win;
   logic [FILL_W-1:0] w_nfill;
   logic              w_hit;

   // Window/fill candidates and the match decision; a pattern load masks any hit.
   always_comb begin
      w_win   = {r_shreg[PAT_W-2:0], x};
      w_nfill = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FILL_W'(1);
      w_hit   = en && !pat_load && (w_nfill == FILL_FULL) && (w_win == r_pat);
   end

   // Next-state logic in priority order: pattern load, valid bit, idle.
   always_comb begin
      w_pat_d   = r_pat;
      w_shreg_d = r_shreg;
      w_fill_d  = r_fill;
      w_y_d     = 1'b0;
      if (pat_load) begin
         w_pat_d   = pat_in;
         w_shreg_d = '0;
         w_fill_d  = '0;
      end else if (en) begin
         w_shreg_d = w_win;
         w_y_d     = w_hit;
         // Non-overlapping mode discards history after a match.
         w_fill_d  = (w_hit && !overlap) ? '0 : w_nfill;
      end
   end

   // Match counter: clear takes effect first, so a coincident hit leaves it at one.
   always_comb begin
      w_cnt_d = r_cnt;
      if (cnt_clr) begin
         w_cnt_d = w_hit ? CNT_W'(1) : '0;
      end else if (w_hit && (r_cnt != '1)) begin
         w_cnt_d = r_cnt + CNT_W'(1);
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pat   <= PAT_RST;
         r_shreg <= '0;
         r_fill  <= '0;
         r_y     <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_pat   <= w_pat_d;
         r_shreg <= w_shreg_d;
         r_fill  <= w_fill_d;
         r_y     <= w_y_d;
         r_cnt   <= w_cnt_d;
      end
   end

   assign y           = r_y;
   assign match_count = r_cnt;
   assign fill        = r_fill;

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// Self-checking bench for moore_seq_detector_param: a vector table for the basic
// overlap/non-overlap streams plus directed sequences for the multi-cycle corners.
module tb_moore_seq_detector_param;

   logic       clk;
   logic       rst;
   logic       en;
   logic       x;
   logic       overlap;
   logic       pat_load;
   logic [3:0] pat_in;
   logic       cnt_clr;

   logic       y;
   logic [7:0] match_count;
   logic [2:0] fill;
   logic       y_s;
   logic [1:0] match_count_s;
   logic [2:0] fill_s;

   int n_cmp;
   int n_fail;

   moore_seq_detector_param #(.PAT_W(4), .PAT_RST(4'b1001), .CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .x           (x),
      .overlap     (overlap),
      .pat_load    (pat_load),
      .pat_in      (pat_in),
      .cnt_clr     (cnt_clr),
      .y           (y),
      .match_count (match_count),
      .fill        (fill)
   );

   // Narrow-counter copy for saturation checks; shares all stimulus.
   moore_seq_detector_param #(.PAT_W(4), .PAT_RST(4'b1001), .CNT_W(2)) dut_s (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .x           (x),
      .overlap     (overlap),
      .pat_load    (pat_load),
      .pat_in      (pat_in),
      .cnt_clr     (cnt_clr),
      .y           (y_s),
      .match_count (match_count_s),
      .fill        (fill_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst_before;
      logic       x;
      logic       ov;
      logic       exp_y;
      logic [7:0] exp_cnt;
      logic [2:0] exp_fill;
   } vec_t;

   vec_t tbl[24];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs and sample 1 time unit after the rising edge.
   task automatic step(input logic e, input logic xx, input logic ov, input logic ld,
                       input logic [3:0] pi, input logic clr);
      en       = e;
      x        = xx;
      overlap  = ov;
      pat_load = ld;
      pat_in   = pi;
      cnt_clr  = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #2;
      rst = 1'b1;
   endtask

   initial begin
      n_cmp    = 0;
      n_fail   = 0;
      rst      = 1'b0;
      en       = 1'b0;
      x        = 1'b0;
      overlap  = 1'b1;
      pat_load = 1'b0;
      pat_in   = 4'b0000;
      cnt_clr  = 1'b0;

      // Streams 1,0,0,1,1,1,0,0,1,0,0,1 with overlap then without.
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 3'd1};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3'd2};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 3'd3};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd1, 3'd4};
      tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 3'd4};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 3'd4};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 3'd4};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 3'd4};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 3'd4};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 3'd4};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 3'd4};
      tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd3, 3'd4};
      tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 3'd1};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd2};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'd3};
      tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 3'd0};
      tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 3'd1};
      tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 3'd2};
      tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 3'd3};
      tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 3'd4};
      tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd2, 3'd0};
      tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 3'd1};
      tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 3'd2};
      tbl[23] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 3'd3};

      // Reset state while rst is held low, before any clock edge is used.
      #3;
      chk("reset_y", 32'(y), 32'd0);
      chk("reset_cnt", 32'(match_count), 32'd0);
      chk("reset_fill", 32'(fill), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 24; i++) begin
         if (tbl[i].rst_before) do_reset();
         step(1'b1, tbl[i].x, tbl[i].ov, 1'b0, 4'b0000, 1'b0);
         chk($sformatf("tbl%0d_y", i), 32'(y), 32'(tbl[i].exp_y));
         chk($sformatf("tbl%0d_cnt", i), 32'(match_count), 32'(tbl[i].exp_cnt));
         chk($sformatf("tbl%0d_fill", i), 32'(fill), 32'(tbl[i].exp_fill));
         chk($sformatf("tbl%0d_cnt_s", i), 32'(match_count_s),
             32'((tbl[i].exp_cnt > 8'd3) ? 8'd3 : tbl[i].exp_cnt));
      end

      // Pattern reload to 1111 with overlap: y on bits 4,5,6.
      do_reset();
      step(1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b0);
      chk("load_y", 32'(y), 32'd0);
      chk("load_fill", 32'(fill), 32'd0);
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
         chk($sformatf("ones%0d_y", i), 32'(y), (i >= 3) ? 32'd1 : 32'd0);
      end
      chk("ones_cnt", 32'(match_count), 32'd3);

      // Asynchronous reset mid-stream, then the reset pattern 1001 must be back.
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
      rst = 1'b0;
      #1;
      chk("async_y", 32'(y), 32'd0);
      chk("async_cnt", 32'(match_count), 32'd0);
      chk("async_fill", 32'(fill), 32'd0);
      #1;
      rst = 1'b1;
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
      chk("rst_pat_pre_y", 32'(y), 32'd0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
      chk("rst_pat_y", 32'(y), 32'd1);
      chk("rst_pat_cnt", 32'(match_count), 32'd1);

      // Enable gaps: 1,0,(gap x3 with x=1),0,1 -> one pulse after the last bit.
      do_reset();
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
         chk($sformatf("gap%0d_y", i), 32'(y), 32'd0);
         chk($sformatf("gap%0d_fill", i), 32'(fill), 32'd2);
      end
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
      chk("gap_pre_y", 32'(y), 32'd0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
      chk("gap_hit_y", 32'(y), 32'd1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
      chk("gap_post_y", 32'(y), 32'd0);
      chk("gap_cnt", 32'(match_count), 32'd1);

      // Saturation: 1001001001001001 with overlap gives five matches.
      do_reset();
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
         step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
         step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
      end
      chk("sat_cnt_wide", 32'(match_count), 32'd5);
      chk("sat_cnt_narrow", 32'(match_count_s), 32'd3);

      // Clear coincident with a hit leaves the count at one.
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
      chk("clr_hit_y", 32'(y), 32'd1);
      chk("clr_hit_cnt", 32'(match_count), 32'd1);
      chk("clr_hit_cnt_s", 32'(match_count_s), 32'd1);
      // Plain clear without a hit.
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1);
      chk("clr_cnt", 32'(match_count), 32'd0);

      // A pattern load must not touch the counter.
      step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
      chk("pre_load_cnt", 32'(match_count), 32'd1);
      step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0110, 1'b0);
      chk("load_keep_cnt", 32'(match_count), 32'd1);
      chk("load_keep_fill", 32'(fill), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
